// File: rtl/add_sched_pkg.sv
// rtl/add_sched_pkg.sv - shared constants, tag type and helpers for the adder scheduler
package add_sched_pkg;

  localparam int WIDTH   = 37;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int LATENCY = 5;
  localparam int CNTW    = 16;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDW-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/add_pipe_sched_adder.sv
// rtl/add_pipe_sched_adder.sv - 37-bit adder: input register, three carry segments, output register
module add37_pipe #(
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum
);

  localparam int L0 = 13;
  localparam int L1 = 12;
  localparam int L2 = WIDTH - L0 - L1;

  logic [WIDTH-1:0]    xr, yr;
  logic [L0:0]         s0;
  logic [WIDTH-1:L0]   x1, y1;
  logic [L1:0]         s1;
  logic [L0-1:0]       lo2;
  logic [WIDTH-1:L0+L1] x2, y2;
  logic [L2-1:0]       s2;
  logic [L0+L1-1:0]    lo3;

  // Carry out of the top segment is dropped: arithmetic is modulo 2^WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      xr  <= '0;
      yr  <= '0;
      s0  <= '0;
      x1  <= '0;
      y1  <= '0;
      s1  <= '0;
      lo2 <= '0;
      x2  <= '0;
      y2  <= '0;
      s2  <= '0;
      lo3 <= '0;
      sum <= '0;
    end else begin
      xr  <= x;
      yr  <= y;
      s0  <= {1'b0, xr[L0-1:0]} + {1'b0, yr[L0-1:0]};
      x1  <= xr[WIDTH-1:L0];
      y1  <= yr[WIDTH-1:L0];
      s1  <= {1'b0, x1[L0+L1-1:L0]} + {1'b0, y1[L0+L1-1:L0]} + {{L1{1'b0}}, s0[L0]};
      lo2 <= s0[L0-1:0];
      x2  <= x1[WIDTH-1:L0+L1];
      y2  <= y1[WIDTH-1:L0+L1];
      s2  <= x2 + y2 + {{(L2-1){1'b0}}, s1[L1]};
      lo3 <= {s1[L1-1:0], lo2};
      sum <= {s2, lo3};
    end
  end

endmodule

// File: rtl/add_pipe_sched_rr_arbiter.sv
// rtl/add_pipe_sched_rr_arbiter.sv - combinational round-robin arbiter
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id
);

  int j;

  // Walk offsets from farthest to nearest so the nearest eligible index from ptr wins.
  always_comb begin
    gnt = '0;
    id  = '0;
    j   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (elig[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        id     = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/add_pipe_sched.sv
// rtl/add_pipe_sched.sv - round-robin sharing of one pipelined adder among NREQ requesters
module add_pipe_sched
  import add_sched_pkg::*;
#(
  parameter int WIDTH   = add_sched_pkg::WIDTH,
  parameter int NREQ    = add_sched_pkg::NREQ,
  parameter int IDW     = add_sched_pkg::IDW,
  parameter int LATENCY = add_sched_pkg::LATENCY,
  parameter int CNTW    = add_sched_pkg::CNTW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      add_x,
  output logic [WIDTH-1:0]      add_y,
  input  logic [WIDTH-1:0]      add_sum,
  output logic [NREQ-1:0]       res_valid,
  output logic [NREQ*WIDTH-1:0] res_data,
  input  logic [NREQ-1:0]       res_ack,
  output logic [NREQ-1:0]       busy,
  output logic [CNTW-1:0]       op_count
);

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt_arb;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_next;
  logic            accept;
  logic [NREQ-1:0] ack_hit;
  logic [NREQ-1:0] cap_mask;
  tag_t            tags [LATENCY+1];

  assign elig = req & ~busy;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .elig(elig),
    .ptr (ptr),
    .gnt (gnt_arb),
    .id  (gnt_id)
  );

  assign gnt      = reset ? '0 : gnt_arb;
  assign accept   = |gnt;
  assign ptr_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
  assign ack_hit  = res_ack & res_valid;
  assign cap_mask = tags[LATENCY].valid ? idx_to_onehot(tags[LATENCY].id) : '0;

  // The tag in the last stage names the owner of the sum currently on add_sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      add_x     <= '0;
      add_y     <= '0;
      ptr       <= '0;
      op_count  <= '0;
      busy      <= '0;
      res_valid <= '0;
      res_data  <= '0;
      for (int k = 0; k <= LATENCY; k++) tags[k] <= '0;
    end else begin
      if (accept) begin
        add_x    <= req_x[gnt_id*WIDTH +: WIDTH];
        add_y    <= req_y[gnt_id*WIDTH +: WIDTH];
        ptr      <= ptr_next;
        op_count <= op_count + CNTW'(1);
      end
      tags[0].valid <= accept;
      tags[0].id    <= gnt_id;
      for (int k = 1; k <= LATENCY; k++) tags[k] <= tags[k-1];
      busy      <= (busy & ~ack_hit) | gnt;
      res_valid <= (res_valid & ~ack_hit) | cap_mask;
      if (tags[LATENCY].valid) res_data[tags[LATENCY].id*WIDTH +: WIDTH] <= add_sum;
    end
  end

endmodule

// File: tb/tb_add_pipe_sched.sv
// tb/tb_add_pipe_sched.sv - scoreboard bench for add_pipe_sched driving a real pipelined adder
module tb_add_pipe_sched;

  localparam int W   = 37;
  localparam int N   = 4;
  localparam int LAT = 5;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*W-1:0]    req_x, req_y;
  logic [N-1:0]      gnt;
  logic [W-1:0]      add_x, add_y, add_sum;
  logic [N-1:0]      res_valid;
  logic [N*W-1:0]    res_data;
  logic [N-1:0]      res_ack;
  logic [N-1:0]      busy;
  logic [CW-1:0]     op_count;

  add_pipe_sched #(
    .WIDTH(W), .NREQ(N), .IDW(2), .LATENCY(LAT), .CNTW(CW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y), .gnt(gnt),
    .add_x(add_x), .add_y(add_y), .add_sum(add_sum), .res_valid(res_valid),
    .res_data(res_data), .res_ack(res_ack), .busy(busy), .op_count(op_count)
  );

  add37_pipe #(.WIDTH(W)) u_adder (
    .clk(clk), .reset(reset), .x(add_x), .y(add_y), .sum(add_sum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           id;
    logic [W-1:0] sum;
    int           due;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [N-1:0] m_busy, m_rv, m_infl;
  int           m_due [N];
  logic [W-1:0] m_sum [N];
  logic [W-1:0] m_data[N];
  logic [W-1:0] opx[N], opy[N];
  logic [W-1:0] m_ax, m_ay;
  int           m_ptr, m_cnt;
  bit           wrap_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return v[W-1:0];
    endcase
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      opx[i] = rnd_op();
      opy[i] = rnd_op();
    end
  endtask

  task automatic model_clear();
    m_busy = '0; m_rv = '0; m_infl = '0;
    m_ptr = 0; m_cnt = 0; m_ax = '0; m_ay = '0; wrap_pend = 0;
    for (int i = 0; i < N; i++) begin
      m_due[i] = 0; m_sum[i] = '0; m_data[i] = '0;
    end
    sbq.delete();
  endtask

  // One clock: check registered state, drive inputs, check grant, advance the model.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] a,
                      input logic [N-1:0] auto_ack, input bit rst, output int g);
    logic [N-1:0] ack, exp_gnt;
    logic [W:0]   full;
    for (int i = 0; i < N; i++) begin
      if (m_infl[i] && cyc >= m_due[i]) begin
        m_infl[i] = 1'b0;
        m_rv[i]   = 1'b1;
        m_data[i] = m_sum[i];
      end
    end
    chk("busy", busy, m_busy);
    chk("res_valid", res_valid, m_rv);
    for (int i = 0; i < N; i++) chk("res_data", res_data[i*W +: W], m_data[i]);
    chk("op_count", op_count, m_cnt);
    chk("add_x", add_x, m_ax);
    chk("add_y", add_y, m_ay);
    if (wrap_pend) begin
      chk("op_count_wrap", op_count, 0);
      wrap_pend = 0;
    end

    ack = a | (m_rv & auto_ack);
    reset   = rst;
    req     = r;
    res_ack = ack;
    for (int i = 0; i < N; i++) begin
      req_x[i*W +: W] = opx[i];
      req_y[i*W +: W] = opy[i];
    end
    #1;

    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (g < 0 && r[j] && !m_busy[j]) g = j;
      end
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    chk("gnt", gnt, exp_gnt);

    if (rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ack[i] && m_rv[i]) begin
          m_rv[i]   = 1'b0;
          m_busy[i] = 1'b0;
        end
      end
      if (g >= 0) begin
        full       = {1'b0, opx[g]} + {1'b0, opy[g]};
        m_busy[g]  = 1'b1;
        m_infl[g]  = 1'b1;
        m_due[g]   = cyc + 1 + LAT + 1;
        m_sum[g]   = full[W-1:0];
        sbq.push_back('{g, full[W-1:0], m_due[g]});
        m_ptr      = (g + 1) % N;
        m_cnt      = (m_cnt + 1) % (1 << CW);
        if (m_cnt == 0) wrap_pend = 1;
        m_ax       = opx[g];
        m_ay       = opy[g];
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int g;
    int n = 0;
    while ((sbq.size() != 0 || m_busy != '0) && n < 40) begin
      step('0, '0, '1, 0, g);
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d results still outstanding after %0d cycles", sbq.size(), n);
    end
  endtask

  // Monitor: every newly raised res_valid must match the oldest expected result.
  initial begin
    logic [N-1:0] prev;
    exp_t         e;
    prev = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (res_valid[i] === 1'b1 && prev[i] !== 1'b1) begin
          if (sbq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL mon_unexpected: result raised in slot %0d with nothing expected", i);
          end else begin
            e = sbq.pop_front();
            chk("mon_slot", i, e.id);
            chk("mon_data", res_data[i*W +: W], e.sum);
            chk("mon_latency", cyc, e.due);
          end
        end
      end
      prev = res_valid;
    end
  end

  initial begin
    int g;
    logic [31:0] rr, ra, rauto;
    reset = 1'b1; req = '0; res_ack = '0; req_x = '0; req_y = '0;
    for (int i = 0; i < N; i++) begin opx[i] = '0; opy[i] = '0; end
    model_clear();
    repeat (2) @(negedge clk);

    chk("rst_gnt", gnt, 0);
    chk("rst_add_x", add_x, 0);
    chk("rst_add_y", add_y, 0);
    chk("rst_res_valid", res_valid, 0);
    for (int i = 0; i < N; i++) chk("rst_res_data", res_data[i*W +: W], 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);

    // Single op with carry rippling through every segment.
    opx[0] = 37'd1;
    opy[0] = 37'h0FFFFFFFFF;
    step(4'b0001, '0, '0, 0, g);
    repeat (6) step('0, '0, '0, 0, g);
    chk("p1_valid", res_valid[0], 1);
    chk("p1_sum", res_data[W-1:0], 37'h1000000000);
    chk("p1_count", op_count, 1);
    drain();

    // Fair sharing from a clean pointer, every result acked as it appears.
    step('0, '0, '0, 1, g);
    for (int k = 0; k < 32; k++) begin
      rand_ops();
      step(4'hF, '0, 4'hF, 0, g);
    end
    drain();

    // Modular wrap of the sum.
    opx[1] = '1;
    opy[1] = 37'd1;
    step(4'b0010, '0, '0, 0, g);
    repeat (6) step('0, '0, '0, 0, g);
    chk("p3_valid", res_valid[1], 1);
    chk("p3_wrap", res_data[W +: W], 0);
    drain();

    // Back-to-back accepts 0..3 after reset.
    step('0, '0, '0, 1, g);
    for (int i = 0; i < N; i++) begin
      opx[i] = W'(i);
      opy[i] = W'(10 * i);
    end
    repeat (4) step(4'hF, '0, '0, 0, g);
    repeat (6) step('0, '0, '0, 0, g);
    chk("p4_valid", res_valid, 4'hF);
    for (int i = 0; i < N; i++) chk("p4_sum", res_data[i*W +: W], 11 * i);
    drain();

    // Backpressure on requester 2, then release and immediate regrant.
    for (int k = 0; k < 24; k++) begin
      rand_ops();
      step(4'hF, '0, 4'b1011, 0, g);
    end
    chk("p5_busy2", busy[2], 1);
    chk("p5_held2", res_valid[2], 1);
    step(4'b0100, 4'b0100, 4'b1011, 0, g);
    step(4'b0100, '0, 4'b1011, 0, g);
    chk("p5_busy2_regrant", busy[2], 1);
    drain();

    // Reset pulsed right after three accepts discards their results.
    rand_ops();
    repeat (3) step(4'b0111, '0, '0, 0, g);
    step('0, '0, '0, 1, g);
    repeat (10) step('0, '0, '0, 0, g);
    rand_ops();
    step(4'b0001, '0, '0, 0, g);
    repeat (7) step('0, '0, 4'hF, 0, g);
    drain();

    // Random traffic including stray acks, one mid-run reset, and counter wraps.
    for (int k = 0; k < 3000; k++) begin
      rand_ops();
      rr    = $urandom();
      ra    = $urandom();
      rauto = ($urandom_range(0, 3) == 0) ? $urandom() : '1;
      step(rr[N-1:0], ra[N-1:0], rauto[N-1:0], (k == 700), g);
    end
    drain();
    chk("final_queue_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/add_pipe_sched.md
Name: add_pipe_sched

Overview:
- Round-robin scheduler that shares one pipelined adder between NREQ requesters.
- The adder is a 37-bit, 3-carry-stage unit with registered inputs and a fixed latency of LATENCY clock edges.
- The block grants at most one operand pair per cycle and drives the adder inputs.
- It tracks each in-flight operation with a tag pipeline matched to the adder latency and returns each sum to its requester through a held result register with an acknowledge.

Parameters:
- WIDTH, 37, operand and sum width; must equal the adder width.
- NREQ, 4, number of requesters, 2..8.
- IDW, 2, requester index width, equal to ceil(log2(NREQ)).
- LATENCY, 5, clock edges from the adder sampling add_x/add_y to its sum being stable.
- CNTW, 16, width of the accepted-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request.
- req_x  in  NREQ*WIDTH  operand x; requester i occupies bits [i*WIDTH +: WIDTH].
- req_y  in  NREQ*WIDTH  operand y; same packing as req_x.
- gnt  out  NREQ  combinational one-hot grant; a request is accepted when req[i] & gnt[i].
- add_x  out  WIDTH  registered operand x to the adder.
- add_y  out  WIDTH  registered operand y to the adder.
- add_sum  in  WIDTH  adder result.
- res_valid  out  NREQ  per-requester result valid; held until acknowledged.
- res_data  out  NREQ*WIDTH  per-requester sum, same packing as req_x.
- res_ack  in  NREQ  per-requester result acknowledge.
- busy  out  NREQ  requester has an op in flight or an unacknowledged result.
- op_count  out  CNTW  number of accepted operations.

Behaviour:
- Reset values: gnt=0, add_x=0, add_y=0, res_valid=0, res_data=0, busy=0, op_count=0, rr pointer=0, all tag-pipeline valid bits=0.
- Eligibility: elig[i] = req[i] & ~busy[i], where busy is registered state. Each requester has at most one operation outstanding.
- Arbitration: search elig starting at index ptr, wrapping modulo NREQ. The first hit gets gnt (one-hot). No eligible requester gives gnt=0. gnt is also forced to 0 while reset is high.
- On accept at edge E0:
  - add_x/add_y load the granted requester's operands.
  - Tag stage 0 loads {valid=1, id}.
  - busy[id] sets.
  - ptr becomes (id+1) mod NREQ.
  - op_count increments and wraps from 2^CNTW-1 to 0.
- No accept: add_x/add_y hold their values; tag stage 0 valid=0; ptr holds.
- Tag pipeline: LATENCY+1 stages. Stage k is loaded at edge E0+k.
- When the last stage is valid, edge E0+LATENCY+1 captures add_sum into res_data[id] and sets res_valid[id].
- Request-to-result latency: res_valid rises LATENCY+1 cycles after the accept edge (6 cycles at the default). Throughput is 1 op/cycle across requesters.
- res_ack[i] with res_valid[i]=1: res_valid[i] and busy[i] clear at that edge. The earliest regrant of i is the following cycle. res_data[i] holds its last value.
- res_ack[i] with res_valid[i]=0 is ignored.
- res_ack and result capture for the same i in the same cycle cannot occur, because of the one-outstanding rule. Capture for requester i and ack for requester j≠i in the same cycle are both honoured.
- Arithmetic is modulo 2^WIDTH. Carry-out is not reported; add_sum is taken as-is.
- Reset asserted mid-operation clears every tag valid, busy and res_valid. In-flight sums are discarded, and add_sum is ignored until new tags reach the last stage.
- req[i] deasserting after grant has no effect on the in-flight op.

Decomposition:
- Package add_sched_pkg holds:
  - default constants WIDTH, NREQ, IDW, LATENCY;
  - the tag struct {valid, id[IDW-1:0]};
  - an index-to-one-hot helper function.
- Sub-module rr_arbiter(NREQ): inputs elig and ptr; output one-hot gnt and encoded id; purely combinational.
- Pointer, tag pipeline, result registers and counter live in add_pipe_sched.
- The bench instantiates the real 37-bit pipelined adder on add_x/add_y/add_sum.

Test Plan:
- Single op: after reset, req[0]=1, x=1, y=2^36-1 for one accepted cycle -> gnt=0001 that cycle; res_valid[0] rises 6 cycles after accept with res_data[0]=2^36 (carry through all segments); op_count=1.
- Fair sharing: req=1111 held, each result acked the cycle it appears -> grants in order 0,1,2,3, then 0 again only after its ack; no requester granted twice while busy.
- Wrap/overflow: x=2^37-1, y=1 -> res_data=0. Separately, op_count preloaded to 65535 by 65535 accepts, then one more accept -> 0.
- Back-to-back: requesters 0..3 accepted on 4 consecutive cycles with x=i, y=10*i -> results 0, 11, 22, 33 appear on 4 consecutive cycles, each in the correct slot.
- Backpressure: requester 2 result not acked for 20 cycles with req[2] held -> gnt[2] stays 0 and other requesters keep being served; ack -> busy[2] clears and gnt[2] is possible the next cycle.
- Reset mid-flight: 3 ops accepted, reset pulsed 1 cycle at the cycle after the last accept -> res_valid stays 0 for 10 cycles; a fresh request then completes normally with correct data.
